// File: rtl/ngs_dac_pkg.sv
// Shared constants and sizing helpers for the
// stereo DAC serializer.
package ngs_dac_pkg;

  localparam int DEF_SLOT_W     = 16;
  localparam int DEF_BITCK_DIV  = 2;
  localparam int DEF_FRAME_BITS = 2 * DEF_SLOT_W;

  function automatic int cnt_width(input int slot_w);
    return $clog2(2 * slot_w);
  endfunction

  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/dac_bitclk_gen.sv
// Bit clock divider, frame bit counter and
// word-select generation for the DAC serializer.
module dac_bitclk_gen
  import ngs_dac_pkg::*;
#(
  parameter int SLOT_W    = DEF_SLOT_W,
  parameter int BITCK_DIV = DEF_BITCK_DIV,
  localparam int CW = cnt_width(SLOT_W),
  localparam int DW = div_width(BITCK_DIV)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic          bitck_o,
  output logic          lrck_o,
  output logic          fall_evt_o,
  output logic          frame_start_o,
  output logic [CW-1:0] bit_cnt_o
);

  localparam logic [DW-1:0] DIV_TC   = DW'(BITCK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * SLOT_W - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(SLOT_W - 1);

  logic [DW-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          bitck_q;
  logic          lrck_q;
  logic          tc;

  assign tc            = (div_q == DIV_TC);
  assign fall_evt_o    = en_i & tc & bitck_q;
  assign frame_start_o = fall_evt_o & (cnt_q == CNT_LAST);
  assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      bitck_q <= 1'b0;
      cnt_q   <= CNT_LAST;
      lrck_q  <= 1'b0;
    end else if (!en_i) begin
      div_q   <= '0;
      bitck_q <= 1'b0;
      cnt_q   <= CNT_LAST;
      lrck_q  <= 1'b0;
    end else begin
      div_q <= tc ? '0 : div_q + 1'b1;
      if (tc) bitck_q <= ~bitck_q;
      // lrck leads each channel MSB by one bit
      if (fall_evt_o) begin
        cnt_q <= cnt_d;
        if (cnt_d == CNT_MID) lrck_q <= 1'b1;
        else if (cnt_d == CNT_LAST) lrck_q <= 1'b0;
      end
    end
  end

  assign bitck_o   = bitck_q;
  assign lrck_o    = lrck_q;
  assign bit_cnt_o = cnt_q;

endmodule

// File: rtl/dac_serializer.sv
// Stereo PCM to serial DAC stream with a one-entry
// holding register and last-frame repeat on underrun.
module dac_serializer
  import ngs_dac_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_W    = DEF_SLOT_W,
  parameter int BITCK_DIV = DEF_BITCK_DIV
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                underrun,
  output logic                dac_bitck,
  output logic                dac_lrck,
  output logic                dac_dat
);

  localparam int FW  = 2 * SLOT_W;
  localparam int PAD = SLOT_W - SAMPLE_W;
  localparam int CW  = cnt_width(SLOT_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(FW - 1);

  logic                full_q;
  logic [SAMPLE_W-1:0] hold_l_q;
  logic [SAMPLE_W-1:0] hold_r_q;
  logic [FW-1:0]       sh_q;
  logic [FW-1:0]       last_q;
  logic                ur_q;
  logic [SLOT_W-1:0]   l_slot;
  logic [SLOT_W-1:0]   r_slot;
  logic [FW-1:0]       new_frame;
  logic                fall_evt;
  logic                frame_start;
  logic [CW-1:0]       bit_cnt;

  dac_bitclk_gen #(
    .SLOT_W   (SLOT_W),
    .BITCK_DIV(BITCK_DIV)
  ) u_bclk (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .bitck_o      (dac_bitck),
    .lrck_o       (dac_lrck),
    .fall_evt_o   (fall_evt),
    .frame_start_o(frame_start),
    .bit_cnt_o    (bit_cnt)
  );

  // Samples sit left-justified in their slot
  assign l_slot    = SLOT_W'(hold_l_q) << PAD;
  assign r_slot    = SLOT_W'(hold_r_q) << PAD;
  assign new_frame = {l_slot, r_slot};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      sh_q     <= '0;
      last_q   <= '0;
      ur_q     <= 1'b0;
    end else begin
      if (in_valid && !full_q) begin
        full_q   <= 1'b1;
        hold_l_q <= in_left;
        hold_r_q <= in_right;
      end else if (frame_start && full_q) begin
        full_q <= 1'b0;
      end
      ur_q <= frame_start & ~full_q;
      if (!en) begin
        sh_q <= '0;
      end else if (frame_start) begin
        if (full_q) begin
          sh_q   <= new_frame;
          last_q <= new_frame;
        end else begin
          sh_q <= last_q;
        end
      end else if (fall_evt) begin
        sh_q <= {sh_q[FW-2:0], 1'b0};
      end
    end
  end

  a_frame_at_wrap: assert property (
    @(posedge clk) disable iff (!rst_n)
    frame_start |-> (bit_cnt == CNT_LAST)
  );

  assign in_ready = ~full_q;
  assign underrun = ur_q;
  assign dac_dat  = sh_q[FW-1];

endmodule

// File: tb/tb_dac_serializer.sv
// Self-checking bench for dac_serializer at
// default parameters (16/16/2).
module tb_dac_serializer;

  localparam int SW  = 16;
  localparam int SL  = 16;
  localparam int DIV = 2;
  localparam logic [31:0] LR_PAT = 32'h0001_FFFE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [SW-1:0] in_left = '0;
  logic [SW-1:0] in_right = '0;
  logic          in_ready;
  logic          underrun;
  logic          dac_bitck;
  logic          dac_lrck;
  logic          dac_dat;

  always #5 clk = ~clk;

  dac_serializer #(
    .SAMPLE_W (SW),
    .SLOT_W   (SL),
    .BITCK_DIV(DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_left  (in_left),
    .in_right (in_right),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .underrun (underrun),
    .dac_bitck(dac_bitck),
    .dac_lrck (dac_lrck),
    .dac_dat  (dac_dat)
  );

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        valid;
    logic [15:0] l;
    logic [15:0] r;
    logic        rdy;
    logic        ur;
    logic        bck;
    logic        lr;
    logic        dat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Frame monitor: collects bits on bitck rises
  int          mk = 0;
  logic        pb = 1'b0;
  logic [31:0] fw = '0;
  logic [31:0] lw = '0;
  logic [31:0] got_f [64];
  logic [31:0] got_l [64];
  int          got_n = 0;
  int          ur_cnt = 0;

  always @(negedge clk) begin
    if (underrun) ur_cnt <= ur_cnt + 1;
    if (!rst_n || !en) begin
      mk <= 0;
      pb <= 1'b0;
    end else begin
      pb <= dac_bitck;
      if (dac_bitck && !pb) begin
        mk <= mk + 1;
        if (mk > 0) begin
          fw <= {fw[30:0], dac_dat};
          lw <= {lw[30:0], dac_lrck};
          if ((mk - 1) % 32 == 31 && got_n < 64) begin
            got_f[got_n] <= {fw[30:0], dac_dat};
            got_l[got_n] <= {lw[30:0], dac_lrck};
            got_n <= got_n + 1;
          end
        end
      end
    end
  end

  logic [31:0] sb[$];
  int rd = 0;
  int ur_base = 0;
  int b2b = 0;
  int acc = 0;
  int pair = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_pair();
    in_left  = 16'h0100 + 16'(pair);
    in_right = 16'hF000 - 16'(pair);
    sb.push_back({in_left, in_right});
  endtask

  task automatic run(input int n);
    logic rdy;
    for (int i = 0; i < n; i++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (b2b != 0 && in_valid && rdy) begin
        acc++;
        pair++;
        drive_pair();
      end
    end
  endtask

  task automatic reset_start();
    in_valid = 1'b0;
    b2b = 0;
    en = 1'b1;
    rst_n = 1'b0;
    run(3);
    sb.delete();
    rd = got_n;
    ur_base = ur_cnt;
    rst_n = 1'b1;
  endtask

  task automatic check_frames(input string nm,
                              input int nexp,
                              input int urexp);
    logic [31:0] e;
    chk({nm, "_frames"}, 32'(got_n - rd), 32'(nexp));
    chk({nm, "_underruns"}, 32'(ur_cnt - ur_base),
        32'(urexp));
    while (rd < got_n) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb: frame %h with no expectation",
                 nm, got_f[rd]);
      end else begin
        e = sb.pop_front();
        chk({nm, "_data"}, got_f[rd], e);
        chk({nm, "_lrck"}, got_l[rd], LR_PAT);
      end
      rd++;
    end
    sb.delete();
  endtask

  vec_t tv [12];

  initial begin
    for (int i = 0; i < 4; i++)
      tv[i] = '{1'b0, 1'b1, 1'b0, 16'h8001, 16'h7FFE,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1, 1, 0, 16'h8001, 16'h7FFE, 1, 0, 0, 0, 0};
    tv[5]  = '{1, 1, 1, 16'h8001, 16'h7FFE, 0, 0, 1, 0, 0};
    tv[6]  = '{1, 1, 0, 16'h8001, 16'h7FFE, 0, 0, 1, 0, 0};
    tv[7]  = '{1, 1, 0, 16'h8001, 16'h7FFE, 1, 0, 0, 0, 1};
    tv[8]  = '{1, 1, 0, 16'h8001, 16'h7FFE, 1, 0, 0, 0, 1};
    tv[9]  = '{1, 1, 0, 16'h8001, 16'h7FFE, 1, 0, 1, 0, 1};
    tv[10] = '{1, 1, 0, 16'h8001, 16'h7FFE, 1, 0, 1, 0, 1};
    tv[11] = '{1, 1, 0, 16'h8001, 16'h7FFE, 1, 0, 0, 0, 0};

    // Reset, single frame, then one underrun repeat
    sb.push_back(32'h8001_7FFE);
    sb.push_back(32'h8001_7FFE);
    rd = got_n;
    ur_base = ur_cnt;
    for (int i = 0; i < 12; i++) begin
      rst_n    = tv[i].rst_n;
      en       = tv[i].en;
      in_valid = tv[i].valid;
      in_left  = tv[i].l;
      in_right = tv[i].r;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(in_ready),
          32'(tv[i].rdy));
      chk($sformatf("v%0d_underrun", i), 32'(underrun),
          32'(tv[i].ur));
      chk($sformatf("v%0d_bitck", i), 32'(dac_bitck),
          32'(tv[i].bck));
      chk($sformatf("v%0d_lrck", i), 32'(dac_lrck),
          32'(tv[i].lr));
      chk($sformatf("v%0d_dat", i), 32'(dac_dat),
          32'(tv[i].dat));
    end
    in_valid = 1'b0;
    run(256);
    check_frames("single", 2, 2);

    // Idle: no input, zero frames, underrun every frame
    reset_start();
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    run(3);
    chk("idle_ur_clk3", 32'(underrun), 32'd0);
    run(1);
    chk("idle_ur_clk4", 32'(underrun), 32'd1);
    run(1);
    chk("idle_ur_clk5", 32'(underrun), 32'd0);
    chk("idle_dat", 32'(dac_dat), 32'd0);
    run(259);
    check_frames("idle", 2, 3);

    // One pair then starve: frame repeats
    reset_start();
    sb.push_back(32'h1234_ABCD);
    sb.push_back(32'h1234_ABCD);
    in_left  = 16'h1234;
    in_right = 16'hABCD;
    in_valid = 1'b1;
    run(1);
    in_valid = 1'b0;
    chk("repeat_ready_low", 32'(in_ready), 32'd0);
    run(263);
    check_frames("repeat", 2, 2);

    // Back-to-back stream with valid held high
    reset_start();
    b2b = 1;
    acc = 0;
    pair = 0;
    drive_pair();
    in_valid = 1'b1;
    run(648);
    b2b = 0;
    in_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd7);
    check_frames("b2b", 5, 0);

    // en drop at bit count 10, then restart
    reset_start();
    sb.push_back(32'h1234_ABCD);
    in_left  = 16'h1234;
    in_right = 16'hABCD;
    in_valid = 1'b1;
    run(1);
    in_valid = 1'b0;
    run(45);
    chk("endrop_pre_bitck", 32'(dac_bitck), 32'd1);
    chk("endrop_pre_dat", 32'(dac_dat), 32'd1);
    en = 1'b0;
    run(1);
    chk("endrop_bitck", 32'(dac_bitck), 32'd0);
    chk("endrop_lrck", 32'(dac_lrck), 32'd0);
    chk("endrop_dat", 32'(dac_dat), 32'd0);
    chk("endrop_ur", 32'(underrun), 32'd0);
    chk("endrop_ready", 32'(in_ready), 32'd1);
    run(3);
    en = 1'b1;
    run(3);
    chk("reen_ur_clk3", 32'(underrun), 32'd0);
    run(1);
    chk("reen_ur_clk4", 32'(underrun), 32'd1);
    chk("reen_dat_msb", 32'(dac_dat), 32'd0);
    run(132);
    check_frames("reen", 1, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_serializer.md
Name: dac_serializer

Overview:
- Converts parallel stereo PCM samples into the serial stream on dac_bitck / dac_lrck / dac_dat at the top-level pins.
- Sits directly upstream of the DAC pins.
- Consumes left/right sample pairs from the sound mixer through a one-entry valid/ready holding register.
- Repeats the last frame on underrun, so the DAC never sees garbage.

Parameters:
- SAMPLE_W, 16: input sample width per channel, two's complement, must be <= SLOT_W.
- SLOT_W, 16: bitck periods per channel slot.
- BITCK_DIV, 2: clk cycles per half-period of dac_bitck, >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  serializer enable; low = stopped, outputs at reset values
- in_left  in  SAMPLE_W  left sample
- in_right  in  SAMPLE_W  right sample
- in_valid  in  1  sample pair valid
- in_ready  out  1  holding register empty, pair accepted when in_valid & in_ready
- underrun  out  1  one-clk pulse: frame started with empty holding register
- dac_bitck  out  1  serial bit clock
- dac_lrck  out  1  word select, 0 = left, 1 = right
- dac_dat  out  1  serial data, MSB first

Behaviour:
- Reset values (async, rst_n low):
  - dac_bitck=0, dac_lrck=0, dac_dat=0, in_ready=1, underrun=0
  - div counter=0, bit counter=2*SLOT_W-1
  - shift register=0, last-frame register=0, holding register empty
- Divider:
  - div counter counts 0..BITCK_DIV-1 while en=1.
  - At terminal count it wraps to 0 and dac_bitck toggles.
  - 0->1 is the rising edge (DAC samples); 1->0 is the falling edge (all data/lrck updates).
- Bit counter, range 0..2*SLOT_W-1:
  - Advances (with wrap) on every falling-edge event.
  - Frame period = 4*SLOT_W*BITCK_DIV clk cycles (128 at defaults).
- Frame load, on the falling edge where the bit counter wraps to 0:
  - If holding register full: shift register <= {left, zero-pad to SLOT_W, right, zero-pad}. The same value goes to the last-frame register. Holding register becomes empty; in_ready=1 from the next clk.
  - If holding register empty: shift register <= last-frame register, and underrun pulses high for exactly that clk.
- dac_dat:
  - Equals the shift register MSB.
  - The register shifts left by one on each non-load falling edge.
  - dac_dat changes in the same clk as dac_bitck falls (both registered).
- dac_lrck (I2S one-bit delay):
  - Set to 1 on the falling edge where the bit counter becomes SLOT_W-1.
  - Cleared to 0 on the falling edge where it becomes 2*SLOT_W-1.
  - So lrck leads each channel's MSB by one bitck.
- First frame after reset release with en=1:
  - Rising edge at clk BITCK_DIV; first falling edge and frame load at clk 2*BITCK_DIV.
  - A pair accepted before that clk is output in the first frame.
- Input handshake:
  - Capture on in_valid & in_ready; in_ready drops the next clk.
  - in_valid while in_ready=0 is ignored (sender holds).
  - Frame load and capture cannot coincide: capture needs empty, load consumes full. A load from the empty state plus a capture in the same clk is allowed; the captured pair waits for the next frame.
- Zero-padding: when SAMPLE_W < SLOT_W, the sample occupies the top SAMPLE_W bits of its slot and the low bits are 0.
- en deassert (any point, mid-frame included):
  - Next clk: divider, bit counter, dac_bitck, dac_lrck, dac_dat and underrun return to reset values.
  - Holding and last-frame registers are retained.
  - Re-assert restarts exactly as after reset.
- rst_n mid-frame: immediate async return to reset values, holding register emptied.

Decomposition:
- Package ngs_dac_pkg:
  - Default SLOT_W / BITCK_DIV constants.
  - Bit-counter width function (clog2 of 2*SLOT_W).
  - Frame-bits constant.
- Sub-module dac_bitclk_gen:
  - Contains the divider, dac_bitck, bit counter, lrck generation.
  - Outputs one-clk fall_evt / frame_start strobes and the bit count.
  - Top module keeps the holding register, shift register, last-frame register, underrun.

Test Plan:
- Reset/idle: rst_n low 5 clk, en=1, no input -> all outputs 0 and in_ready=1 during reset. After release: underrun pulses at clk 4 and every 128 clk after; dac_dat stays 0.
- Single frame: L=16'h8001, R=16'h7FFE offered at clk 1 -> in_ready low at clk 2, high after load at clk 4. Sampling dac_dat on dac_bitck rises gives left bits 1000000000000001 while lrck=0, then 0111111111111110 while lrck=1.
- Underrun repeat: send one pair L=16'h1234, R=16'hABCD, then nothing -> the next frame repeats identical bits and underrun pulses once per frame start.
- Back-to-back: in_valid held high with an incrementing pair every accept -> exactly one accept per 128 clk, no underrun, no pair skipped or duplicated.
- lrck alignment: check lrck rises one bitck before the right MSB (bit count 15) and falls one bitck before the left MSB (bit count 31).
- en drop mid-frame at bit count 10 -> next clk bitck/lrck/dat=0. Re-enable restarts the frame with the retained last frame, then underrun if the holding register is still empty.
